regfile_cc: RTL and testbench

- Register-file and condition-code stage of the eLC-3 datapath.
- Sources the two operands consumed by the ALU (SR1_OUT is ALU input A; SR2_OUT is the register option for ALU input B).
- Captures write-back data from the internal bus into R0-R7.
- Holds the NZP condition-code register and the branch-enable flag BEN used by the control FSM.

---
 rtl/regfile_cc.sv | 87 ++++++++
 tb/tb_regfile_cc.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/regfile_cc.sv
// Register file R0-R7 with NZP condition codes and branch-enable flag for the eLC-3 datapath.
// Latency: reads are combinational, writes/NZP/BEN land on the next rising Clk. No backpressure.
// Optional REGFILE_BYPASS_EN: write-through of BUS to a read port addressing DR while LD_REG is high.
module regfile_cc #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] BUS,
    input  logic              LD_REG,
    input  logic [2:0]        DR,
    input  logic [2:0]        SR1,
    input  logic [2:0]        SR2,
    input  logic              LD_CC,
    input  logic              LD_BEN,
    input  logic [2:0]        IR_NZP,
    output logic [DATA_W-1:0] SR1_OUT,
    output logic [DATA_W-1:0] SR2_OUT,
    output logic [2:0]        NZP,
    output logic              BEN
);

    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [2:0]        nzp_q;
    logic [2:0]        nzp_nxt;
    logic              ben_q;
    logic              ben_nxt;
    logic [DATA_W-1:0] sr1_stored;
    logic [DATA_W-1:0] sr2_stored;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (LD_REG) begin
            regs[DR] <= BUS;
        end
    end

    // Sign bit wins, so the decode is one-hot by construction.
    always_comb begin
        nzp_nxt = CC_P;
        if (BUS[DATA_W-1]) begin
            nzp_nxt = CC_N;
        end else if (BUS == '0) begin
            nzp_nxt = CC_Z;
        end
    end

    // BEN samples nzp_q before it moves, so a same-edge LD_CC is not seen.
    assign ben_nxt = |(IR_NZP & nzp_q);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            nzp_q <= CC_Z;
            ben_q <= 1'b0;
        end else begin
            if (LD_CC) begin
                nzp_q <= nzp_nxt;
            end
            if (LD_BEN) begin
                ben_q <= ben_nxt;
            end
        end
    end

    assign sr1_stored = regs[SR1];
    assign sr2_stored = regs[SR2];

`ifdef REGFILE_BYPASS_EN
    assign SR1_OUT = (LD_REG && (SR1 == DR)) ? BUS : sr1_stored;
    assign SR2_OUT = (LD_REG && (SR2 == DR)) ? BUS : sr2_stored;
`else
    assign SR1_OUT = sr1_stored;
    assign SR2_OUT = sr2_stored;
`endif

    assign NZP = nzp_q;
    assign BEN = ben_q;

endmodule

// File: tb/tb_regfile_cc.sv
// Directed bench for regfile_cc: reset, readback, NZP decode, BEN ordering, bypass and reset-during-write.
module tb_regfile_cc;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] BUS;
    logic        LD_REG;
    logic [2:0]  DR;
    logic [2:0]  SR1;
    logic [2:0]  SR2;
    logic        LD_CC;
    logic        LD_BEN;
    logic [2:0]  IR_NZP;
    logic [15:0] SR1_OUT;
    logic [15:0] SR2_OUT;
    logic [2:0]  NZP;
    logic        BEN;

    int checks = 0;
    int errors = 0;

    logic [15:0] vals [8];
    logic [15:0] exp_same;

    regfile_cc #(.DATA_W(16), .NUM_REGS(8)) dut (
        .Clk(Clk), .Reset(Reset), .BUS(BUS), .LD_REG(LD_REG), .DR(DR),
        .SR1(SR1), .SR2(SR2), .LD_CC(LD_CC), .LD_BEN(LD_BEN), .IR_NZP(IR_NZP),
        .SR1_OUT(SR1_OUT), .SR2_OUT(SR2_OUT), .NZP(NZP), .BEN(BEN)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        vals[0] = 16'h0F0F; vals[1] = 16'h1357; vals[2] = 16'h2468; vals[3] = 16'h369C;
        vals[4] = 16'h4BAD; vals[5] = 16'h5AA5; vals[6] = 16'h6C3E; vals[7] = 16'h7001;

        Reset = 1'b1; BUS = '0; LD_REG = 0; DR = 0; SR1 = 0; SR2 = 0;
        LD_CC = 0; LD_BEN = 0; IR_NZP = 0;
        tick(); tick();
        check("rst_sr1", SR1_OUT, 16'h0000);
        check("rst_sr2", SR2_OUT, 16'h0000);
        check("rst_nzp", NZP, 3'b010);
        check("rst_ben", BEN, 1'b0);
        Reset = 1'b0;
        tick();

        // single write then readback
        LD_REG = 1; DR = 3; BUS = 16'h1234;
        tick();
        LD_REG = 0; SR1 = 3; SR2 = 0;
        #1;
        check("wr_r3_sr1", SR1_OUT, 16'h1234);
        check("wr_r0_sr2", SR2_OUT, 16'h0000);

        for (int i = 0; i < 8; i++) begin
            LD_REG = 1; DR = 3'(i); BUS = vals[i];
            tick();
        end
        LD_REG = 0;
        for (int i = 0; i < 8; i++) begin
            SR1 = 3'(i); SR2 = 3'(7 - i);
            #1;
            check($sformatf("rd_sr1_r%0d", i), SR1_OUT, vals[i]);
            check($sformatf("rd_sr2_r%0d", 7 - i), SR2_OUT, vals[7 - i]);
        end

        // BEN set from reset NZP=Z, then async reset between edges
        LD_BEN = 1; IR_NZP = 3'b111;
        tick();
        LD_BEN = 0;
        check("ben_111_z", BEN, 1'b1);
        SR1 = 1; SR2 = 6;
        #2 Reset = 1'b1;
        #1;
        check("arst_sr1", SR1_OUT, 16'h0000);
        check("arst_sr2", SR2_OUT, 16'h0000);
        check("arst_nzp", NZP, 3'b010);
        check("arst_ben", BEN, 1'b0);
        tick();
        Reset = 1'b0;
        tick();

        // condition-code decode
        LD_CC = 1; BUS = 16'h8001; tick(); check("cc_neg", NZP, 3'b100);
        BUS = 16'h0000; tick(); check("cc_zero", NZP, 3'b010);
        BUS = 16'h7FFF; tick(); check("cc_pos", NZP, 3'b001);
        LD_CC = 0; BUS = 16'h8000; tick(); check("cc_hold", NZP, 3'b001);

        // BEN uses NZP from before the edge
        LD_CC = 1; BUS = 16'hFFFF; LD_BEN = 1; IR_NZP = 3'b001;
        tick();
        check("ben_old_p", BEN, 1'b1);
        check("ben_nzp_new", NZP, 3'b100);
        LD_CC = 0;
        tick();
        check("ben_new_n", BEN, 1'b0);
        IR_NZP = 3'b100; tick(); check("ben_n_match", BEN, 1'b1);
        IR_NZP = 3'b000; tick(); check("ben_000", BEN, 1'b0);
        IR_NZP = 3'b111; tick(); check("ben_111", BEN, 1'b1);
        LD_BEN = 0; IR_NZP = 3'b000; tick(); check("ben_hold", BEN, 1'b1);

        // LD_REG and LD_CC from the same BUS value
        LD_REG = 1; LD_CC = 1; DR = 2; BUS = 16'h8000;
        tick();
        LD_REG = 0; LD_CC = 0; SR1 = 2;
        #1;
        check("reg_cc_r2", SR1_OUT, 16'h8000);
        check("reg_cc_nzp", NZP, 3'b100);

        // same-cycle write and read
        LD_REG = 1; DR = 5; BUS = 16'h00AA;
        tick();
        LD_REG = 1; DR = 5; BUS = 16'h5555; SR1 = 5; SR2 = 2;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_same = 16'h5555;
`else
        exp_same = 16'h00AA;
`endif
        check("same_cyc_sr1", SR1_OUT, exp_same);
        check("same_cyc_sr2_other", SR2_OUT, 16'h8000);
        tick();
        LD_REG = 0;
        #1;
        check("after_wr_sr1", SR1_OUT, 16'h5555);

        // reset held across a write edge
        LD_REG = 1; DR = 7; BUS = 16'hBEEF; LD_CC = 1; LD_BEN = 1; IR_NZP = 3'b111;
        Reset = 1'b1;
        tick();
        Reset = 1'b0; LD_REG = 0; LD_CC = 0; LD_BEN = 0; SR1 = 7; SR2 = 5;
        #1;
        check("rst_wr_r7", SR1_OUT, 16'h0000);
        check("rst_wr_r5", SR2_OUT, 16'h0000);
        check("rst_wr_nzp", NZP, 3'b010);
        check("rst_wr_ben", BEN, 1'b0);
        tick();
        check("post_rst_r7", SR1_OUT, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
